// File: rtl/instruction_encoder_if.sv
// Instruction-field and program-memory write bus of the instruction encoder.
// master: the loader/memory side that supplies fields and accepts writes.
// slave:  the encoder itself.
interface instruction_encoder_if #(
    parameter int ADDR_BITS = 8
);
    // Decoded instruction fields (valid/ready handshake)
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_opcode;
    logic [3:0]           in_rd;
    logic [3:0]           in_rs;
    logic [3:0]           in_rt;
    logic [2:0]           in_nzp;
    logic [7:0]           in_imm;
    logic                 in_last;

    // Program memory write port (valid/ready handshake)
    logic                 mem_write_valid;
    logic                 mem_write_ready;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [15:0]          mem_write_data;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs, in_rt, in_nzp, in_imm, in_last,
        input  in_ready,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs, in_rt, in_nzp, in_imm, in_last,
        output in_ready,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );
endinterface

// File: rtl/instruction_encoder.sv
// Instruction encoder: packs decoded fields into 16-bit GPU ISA words, buffers
// them in a small FIFO and streams them into program memory at auto-incrementing
// addresses. Illegal opcodes (A-E) set a sticky error and end the session.
// Optional feature: define INSTR_ENCODER_CHECKSUM_EN to add a 16-bit
// rotate-xor checksum output over all words written in the session.
module instruction_encoder #(
    parameter int ADDR_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  base_address,
    instruction_encoder_if.slave  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_BITS:0]    words_written
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_BR    = 4'h1,
        OP_CMP   = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_MUL   = 4'h5,
        OP_DIV   = 4'h6,
        OP_LDR   = 4'h7,
        OP_STR   = 4'h8,
        OP_CONST = 4'h9,
        OP_RET   = 4'hF
    } opcode_e;

    typedef struct packed {
        logic        legal;
        logic [15:0] word;
    } enc_t;

    // Field packing; fields an opcode does not use are forced to zero.
    function automatic enc_t encode(input logic [3:0] op,
                                    input logic [3:0] rd,
                                    input logic [3:0] rs,
                                    input logic [3:0] rt,
                                    input logic [2:0] nzp,
                                    input logic [7:0] imm);
        enc_t r;
        r.legal = 1'b1;
        r.word  = 16'h0000;
        case (op)
            OP_NOP:                         r.word = 16'h0000;
            OP_BR:                          r.word = {op, nzp, 1'b0, imm};
            OP_CMP:                         r.word = {op, 4'h0, rs, rt};
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: r.word = {op, rd, rs, rt};
            OP_LDR:                         r.word = {op, rd, rs, 4'h0};
            OP_STR:                         r.word = {op, 4'h0, rs, rt};
            OP_CONST:                       r.word = {op, rd, imm};
            OP_RET:                         r.word = 16'hF000;
            default:                        r.legal = 1'b0;
        endcase
        return r;
    endfunction

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS:0]   words_q, words_d;
    logic                 error_q, error_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic [15:0]          fifo_mem_q [FIFO_DEPTH];
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [15:0]          checksum_q, checksum_d;
`endif

    enc_t enc;
    logic accept_ok;
    logic in_fire;
    logic push;
    logic pop;
    logic fifo_empty;

    assign fifo_empty = (count_q == '0);

    // Fields are accepted only while loading, with room in the FIFO and no error.
    assign accept_ok = (state_q == S_LOAD) && !full_q && !error_q;

    assign bus.in_ready          = accept_ok;
    assign bus.mem_write_valid   = !fifo_empty;
    assign bus.mem_write_address = addr_q;
    // The head entry is masked when empty so stale storage never reaches the port.
    assign bus.mem_write_data    = fifo_empty ? 16'h0000 : fifo_mem_q[rd_ptr_q];

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    assign checksum      = checksum_q;
`endif

    // Next-state logic for the session FSM, FIFO bookkeeping and write address.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        words_d  = words_q;
        error_d  = error_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif

        enc     = encode(bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt,
                         bus.in_nzp, bus.in_imm);
        in_fire = bus.in_valid && accept_ok;
        push    = in_fire && enc.legal;
        pop     = !fifo_empty && bus.mem_write_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = base_address;
                    words_d = '0;
                    error_d = 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
                    checksum_d = 16'h0000;
`endif
                end
            end
            S_LOAD: begin
                if (in_fire) begin
                    if (!enc.legal) begin
                        error_d = 1'b1;
                        state_d = S_DRAIN;
                    end else if (bus.in_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_BITS'(1);
            words_d  = words_q + (ADDR_BITS + 1)'(1);
`ifdef INSTR_ENCODER_CHECKSUM_EN
            checksum_d = {checksum_q[14:0], checksum_q[15]} ^ bus.mem_write_data;
`endif
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d  = (count_d == CNT_W'(FIFO_DEPTH));
        busy_d  = (state_d == S_LOAD) || (state_d == S_DRAIN);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with non-blocking assignments.
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            words_q  <= '0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            checksum_q <= 16'h0000;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; count and pointers alone say which entries are live.
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= enc.word;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: a driver issues fields and pushes
// the expected {address, word} into a scoreboard queue; an independent monitor
// pops and compares on every completed memory write.
module tb_instruction_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_address;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] words_written;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [15:0] checksum;
    logic [15:0] model_cs;
`endif

    instruction_encoder_if #(.ADDR_BITS(8)) bus ();

    instruction_encoder #(.ADDR_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_address  (base_address),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
`ifdef INSTR_ENCODER_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int rd;
        int rs;
        int rt;
        int nzp;
        int imm;
        bit last;
    } instr_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks   = 0;
    int  n_errors   = 0;
    int  n_writes   = 0;
    int  ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
    int  model_addr;
    int  model_words;
    bit  model_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the ISA field layout; -1 marks an illegal opcode.
    function automatic int model_word(input instr_t i);
        case (i.op)
            0:             return 0;
            1:             return 1 * 4096 + i.nzp * 512 + i.imm;
            2:             return 2 * 4096 + i.rs * 16 + i.rt;
            3, 4, 5, 6:    return i.op * 4096 + i.rd * 256 + i.rs * 16 + i.rt;
            7:             return 7 * 4096 + i.rd * 256 + i.rs * 16;
            8:             return 8 * 4096 + i.rs * 16 + i.rt;
            9:             return 9 * 4096 + i.rd * 256 + i.imm;
            15:            return 15 * 4096;
            default:       return -1;
        endcase
    endfunction

    function automatic instr_t mk(input int op, input int rd, input int rs, input int rt,
                                  input int nzp, input int imm, input bit last);
        instr_t i;
        i.op = op; i.rd = rd; i.rs = rs; i.rt = rt; i.nzp = nzp; i.imm = imm; i.last = last;
        return i;
    endfunction

    function automatic instr_t rand_instr(input bit last);
        int idx;
        idx = $urandom_range(0, 10);
        return mk((idx == 10) ? 15 : idx, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 255), last);
    endfunction

    // Memory-side ready generator.
    initial begin
        bus.mem_write_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.mem_write_ready = 1'b0;
                1:       bus.mem_write_ready = 1'b1;
                default: bus.mem_write_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every completed write must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.mem_write_valid && bus.mem_write_ready) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("unexpected write", 32'(bus.mem_write_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write address", 32'(bus.mem_write_address), 32'(e.addr));
                    check("write data", 32'(bus.mem_write_data), 32'(e.data));
`ifdef INSTR_ENCODER_CHECKSUM_EN
                    model_cs = {model_cs[14:0], model_cs[15]} ^ e.data;
`endif
                end
            end
        end
    end

    // All tasks below are entered and left just after a rising edge.
    task automatic do_start(input logic [7:0] base);
        start        = 1'b1;
        base_address = base;
        model_addr   = base;
        model_words  = 0;
        model_err    = 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
        model_cs     = 16'h0000;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy after start", 32'(busy), 32'd1);
        check("error cleared on start", 32'(error), 32'd0);
        check("words_written cleared on start", 32'(words_written), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input instr_t i);
        int  budget;
        bit  accepted;
        int  w;
        wr_t e;
        budget   = 0;
        accepted = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 4'(i.op);
        bus.in_rd     = 4'(i.rd);
        bus.in_rs     = 4'(i.rs);
        bus.in_rt     = 4'(i.rt);
        bus.in_nzp    = 3'(i.nzp);
        bus.in_imm    = 8'(i.imm);
        bus.in_last   = i.last;
        while (budget < 200) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1'b1;
                break;
            end
            budget++;
        end
        if (!accepted) begin
            check("in_ready timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (accepted) begin
            w = model_word(i);
            if (w < 0) begin
                model_err = 1'b1;
            end else begin
                e.addr = 8'(model_addr);
                e.data = 16'(w);
                exp_q.push_back(e);
                model_addr  = (model_addr + 1) % 256;
                model_words = model_words + 1;
            end
        end
    endtask

    task automatic wait_done();
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 400) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            cyc++;
        end
        check("done pulse seen", 32'(seen), 32'd1);
        if (seen) begin
            check("words_written at done", 32'(words_written), 32'(model_words));
            check("error at done", 32'(error), 32'(model_err));
            check("busy low at done", 32'(busy), 32'd0);
            check("scoreboard drained at done", 32'(exp_q.size()), 32'd0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
            check("checksum at done", 32'(checksum), 32'(model_cs));
`endif
            @(negedge clk);
            check("done is one cycle", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_session(input logic [7:0] base, input instr_t prog[$]);
        do_start(base);
        foreach (prog[k]) begin
            if (model_err) break;
            send(prog[k]);
        end
        wait_done();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " mem_write_valid"},   32'(bus.mem_write_valid),   32'd0);
        check({tag, " mem_write_address"}, 32'(bus.mem_write_address), 32'd0);
        check({tag, " mem_write_data"},    32'(bus.mem_write_data),    32'd0);
        check({tag, " in_ready"},          32'(bus.in_ready),          32'd0);
        check({tag, " busy"},              32'(busy),                  32'd0);
        check({tag, " done"},              32'(done),                  32'd0);
        check({tag, " error"},             32'(error),                 32'd0);
        check({tag, " words_written"},     32'(words_written),         32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t prog[$];
        int     writes_before;

        reset        = 1'b1;
        start        = 1'b0;
        base_address = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_opcode = 4'h0;
        bus.in_rd     = 4'h0;
        bus.in_rs     = 4'h0;
        bus.in_rt     = 4'h0;
        bus.in_nzp    = 3'h0;
        bus.in_imm    = 8'h00;
        bus.in_last   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        ready_mode = 1;
        @(posedge clk);
        #1;

        // Single ADD at base 0x10 -> 16'h3312 @ 0x10.
        prog = '{};
        prog.push_back(mk(3, 3, 1, 2, 7, 8'hFF, 1'b1));
        run_session(8'h10, prog);

        // Every encoding format; unused fields carry junk that must be dropped.
        prog = '{};
        prog.push_back(mk(2,  4'hF, 4, 5, 7, 8'hAA, 1'b0));
        prog.push_back(mk(7,  1, 2, 4'hF, 7, 8'hAA, 1'b0));
        prog.push_back(mk(8,  4'hF, 3, 4, 7, 8'hAA, 1'b0));
        prog.push_back(mk(9,  5, 4'hF, 4'hF, 7, 8'h2A, 1'b0));
        prog.push_back(mk(1,  4'hF, 4'hF, 4'hF, 4, 8'h04, 1'b0));
        prog.push_back(mk(15, 4'hF, 4'hF, 4'hF, 7, 8'hFF, 1'b1));
        run_session(8'h20, prog);

        // Back-pressure: 4 words fill the FIFO, then in_ready must stay low.
        ready_mode = 0;
        @(posedge clk);
        #1;
        do_start(8'h30);
        for (int k = 0; k < 4; k++) send(mk(4, k, k + 1, k + 2, 0, 0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("in_ready low when full", 32'(bus.in_ready), 32'd0);
            check("write held valid", 32'(bus.mem_write_valid), 32'd1);
            check("write address held", 32'(bus.mem_write_address), 32'(exp_q[0].addr));
            check("write data held", 32'(bus.mem_write_data), 32'(exp_q[0].data));
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
        send(mk(5, 9, 8, 7, 0, 0, 1'b1));
        wait_done();

        // Address wrap: FE, FF, 00.
        prog = '{};
        prog.push_back(mk(6, 1, 2, 3, 0, 0, 1'b0));
        prog.push_back(mk(0, 1, 2, 3, 5, 8'h11, 1'b0));
        prog.push_back(mk(9, 2, 0, 0, 0, 8'h7E, 1'b1));
        run_session(8'hFE, prog);

        // Illegal opcode mid-stream.
        prog = '{};
        prog.push_back(mk(3, 1, 1, 1, 0, 0, 1'b0));
        prog.push_back(mk(5, 2, 2, 2, 0, 0, 1'b0));
        prog.push_back(mk(4'hB, 3, 3, 3, 0, 0, 1'b0));
        prog.push_back(mk(3, 4, 4, 4, 0, 0, 1'b1));
        run_session(8'h50, prog);
        repeat (3) @(negedge clk);
        check("error sticky after done", 32'(error), 32'd1);
        @(posedge clk);
        #1;

        // Randomized sessions with random memory back-pressure.
        ready_mode = 2;
        for (int s = 0; s < 4; s++) begin
            int n;
            n = $urandom_range(5, 20);
            prog = '{};
            for (int k = 0; k < n; k++) prog.push_back(rand_instr(k == n - 1));
            run_session(8'($urandom_range(0, 255)), prog);
        end

        // Reset with two words buffered.
        ready_mode = 0;
        @(posedge clk);
        #1;
        do_start(8'h40);
        send(mk(3, 1, 2, 3, 0, 0, 1'b0));
        send(mk(4, 4, 5, 6, 0, 0, 1'b0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check_idle_outputs("mid-session reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_mode = 1;
        writes_before = n_writes;
        repeat (8) @(negedge clk);
        check("no writes after reset", 32'(n_writes), 32'(writes_before));
        check("no valid after reset", 32'(bus.mem_write_valid), 32'd0);

        check("scoreboard empty at end", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
